// File: rtl/key_cursor_ctrl.sv
// Keyboard-driven grid cursor with action pulses and optional held-key auto-repeat.
// Define KEY_AUTOREPEAT_EN to build the DELAY/REPEAT typematic FSM and its 26-bit counter.
module key_cursor_ctrl #(
  parameter int GRID_W        = 16,
  parameter int GRID_H        = 16,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       valid,
  input  logic       makeBreak,
  input  logic [7:0] outCode,
  output logic [4:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       moved,
  output logic       reveal,
  output logic       flag,
  output logic       restart
);

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

  localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
  localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);

  if (GRID_W < 2 || GRID_W > 32 || GRID_H < 2 || GRID_H > 32 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      REPEAT_DELAY > 67108864 || REPEAT_PERIOD > 67108864) begin : g_cfg_err
    $error("key_cursor_ctrl: parameter out of range");
  end

  logic [4:0] x_q, x_d, y_q, y_d;
  logic       moved_q, moved_d, reveal_q, reveal_d, flag_q, flag_d, restart_q, restart_d;
  logic       ev, is_dir, do_move;
  dir_e       code_dir, move_dir;

  assign ev = valid && enable;

  // Both scan-code aliases of a direction collapse to one direction value.
  always_comb begin
    is_dir   = 1'b1;
    code_dir = DIR_UP;
    case (outCode)
      8'h75, 8'h1D: code_dir = DIR_UP;
      8'h72, 8'h1B: code_dir = DIR_DOWN;
      8'h6B, 8'h1C: code_dir = DIR_LEFT;
      8'h74, 8'h23: code_dir = DIR_RIGHT;
      default:      is_dir   = 1'b0;
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_e;

  localparam logic [25:0] DELAY_LAST  = 26'(REPEAT_DELAY - 1);
  localparam logic [25:0] PERIOD_LAST = 26'(REPEAT_PERIOD - 1);

  state_e      state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  dir_e        held_q, held_d;
  logic        tick;

  // A tick that lands on an event cycle still advances the schedule; only its move is dropped.
  always_comb begin
    tick     = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    held_d   = held_q;
    do_move  = 1'b0;
    move_dir = code_dir;
    case (state_q)
      S_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          tick    = 1'b1;
          state_d = S_REPEAT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 26'd1;
      end
      S_REPEAT: begin
        if (cnt_q == PERIOD_LAST) begin
          tick  = 1'b1;
          cnt_d = '0;
        end else cnt_d = cnt_q + 26'd1;
      end
      default: cnt_d = '0;
    endcase
    if (ev && makeBreak && is_dir) begin
      do_move = 1'b1;
      held_d  = code_dir;
      state_d = S_DELAY;
      cnt_d   = '0;
    end else if (ev && !makeBreak && is_dir && code_dir == held_q && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (tick && enable && !valid) begin
      do_move  = 1'b1;
      move_dir = held_q;
    end
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      held_q  <= DIR_UP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end
`else
  always_comb begin
    do_move  = ev && makeBreak && is_dir;
    move_dir = code_dir;
  end
`endif

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    moved_d   = 1'b0;
    reveal_d  = ev && makeBreak && (outCode == 8'h29);
    flag_d    = ev && makeBreak && (outCode == 8'h2B);
    restart_d = ev && makeBreak && (outCode == 8'h76);
    if (restart_d) begin
      x_d     = '0;
      y_d     = '0;
      moved_d = (x_q != '0) || (y_q != '0);
    end else if (do_move) begin
      case (move_dir)
        DIR_UP:    if (y_q != '0)    begin y_d = y_q - 5'd1; moved_d = 1'b1; end
        DIR_DOWN:  if (y_q != Y_MAX) begin y_d = y_q + 5'd1; moved_d = 1'b1; end
        DIR_LEFT:  if (x_q != '0)    begin x_d = x_q - 5'd1; moved_d = 1'b1; end
        default:   if (x_q != X_MAX) begin x_d = x_q + 5'd1; moved_d = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      x_q       <= '0;
      y_q       <= '0;
      moved_q   <= 1'b0;
      reveal_q  <= 1'b0;
      flag_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      moved_q   <= moved_d;
      reveal_q  <= reveal_d;
      flag_q    <= flag_d;
      restart_q <= restart_d;
    end
  end

  assign cursor_x = x_q;
  assign cursor_y = y_q;
  assign moved    = moved_q;
  assign reveal   = reveal_q;
  assign flag     = flag_q;
  assign restart  = restart_q;

endmodule

// File: tb/tb_key_cursor_ctrl.sv
// Random + directed bench for key_cursor_ctrl against a cycle-schedule reference model.
module tb_key_cursor_ctrl;

  localparam int GW = 16, GH = 16, RD = 8, RP = 4;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0, enable = 1'b0, valid = 1'b0, makeBreak = 1'b0;
  logic [7:0] outCode = 8'h00;
  logic [4:0] cursor_x, cursor_y;
  logic       moved, reveal, flag, restart;

  key_cursor_ctrl #(.GRID_W(GW), .GRID_H(GH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .valid(valid),
    .makeBreak(makeBreak), .outCode(outCode), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .moved(moved), .reveal(reveal), .flag(flag), .restart(restart)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0, n_err = 0;

  // Model: cursor position, held direction and the absolute cycle of its next repeat.
  int mx, my, held, next_rep, cyc;
  bit held_act, em, er, ef, ers;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dir_of(input logic [7:0] c);
    case (c)
      8'h75, 8'h1D: return 0;
      8'h72, 8'h1B: return 1;
      8'h6B, 8'h1C: return 2;
      8'h74, 8'h23: return 3;
      default:      return -1;
    endcase
  endfunction

  task automatic model_move(input int d);
    int nx, ny;
    nx = mx; ny = my;
    case (d)
      0: ny = (my > 0) ? my - 1 : 0;
      1: ny = (my < GH - 1) ? my + 1 : GH - 1;
      2: nx = (mx > 0) ? mx - 1 : 0;
      default: nx = (mx < GW - 1) ? mx + 1 : GW - 1;
    endcase
    em = (nx != mx) || (ny != my);
    mx = nx; my = ny;
  endtask

  task automatic model_reset();
    mx = 0; my = 0; held = 0; next_rep = 0; cyc = 0;
    held_act = 0; em = 0; er = 0; ef = 0; ers = 0;
  endtask

  task automatic model_edge(input logic v, input logic mb, input logic [7:0] c, input logic en);
    bit ev, tk;
    int d;
    em = 0; er = 0; ef = 0; ers = 0;
    ev = v && en;
    d  = dir_of(c);
    tk = AR && held_act && (cyc == next_rep);
    if (ev && mb && d >= 0) begin
      model_move(d);
      held_act = AR; held = d; next_rep = cyc + RD;
    end else if (ev && !mb && d >= 0 && held_act && d == held) begin
      held_act = 0;
    end else begin
      if (ev && mb && c == 8'h29) er = 1;
      if (ev && mb && c == 8'h2B) ef = 1;
      if (ev && mb && c == 8'h76) begin
        ers = 1;
        em  = (mx != 0) || (my != 0);
        mx = 0; my = 0;
      end
      if (tk) begin
        if (en && !v) model_move(held);
        next_rep = cyc + RP;
      end
    end
    if (!en) held_act = 0;
    cyc++;
  endtask

  function automatic logic [31:0] outs();
    return {18'd0, cursor_x, cursor_y, moved, reveal, flag, restart};
  endfunction

  function automatic logic [31:0] exp_outs();
    return {18'd0, 5'(mx), 5'(my), em, er, ef, ers};
  endfunction

  task automatic step(input string tag, input logic v, input logic mb, input logic [7:0] c,
                      input logic en);
    valid = v; makeBreak = mb; outCode = c; enable = en;
    @(posedge CLOCK_50);
    model_edge(v, mb, c, en);
    #1;
    chk(tag, outs(), exp_outs());
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic press(input string tag, input logic [7:0] c);
    step(tag, 1'b1, 1'b1, c, 1'b1);
    step(tag, 1'b1, 1'b0, c, 1'b1);
  endtask

  task automatic apply_reset();
    valid = 0; makeBreak = 0; outCode = 8'h00; enable = 1;
    reset = 1'b0;
    #2;
    model_reset();
    chk("reset_async", outs(), 32'd0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b1;
  endtask

  logic [7:0] codes [12] = '{8'h75, 8'h1D, 8'h72, 8'h1B, 8'h6B, 8'h1C, 8'h74, 8'h23,
                             8'h29, 8'h2B, 8'h76, 8'h00};

  initial begin
    model_reset();
    #12;
    apply_reset();

    step("right_make", 1'b1, 1'b1, 8'h74, 1'b1);
    chk("right_first", {22'd0, cursor_x, cursor_y, moved}, {22'd0, 5'd1, 5'd0, 1'b1});
    step("right_break", 1'b1, 1'b0, 8'h74, 1'b1);
    chk("moved_one_cycle", {31'd0, moved}, 32'd0);

    press("restart_home", 8'h76);
    step("up_blocked", 1'b1, 1'b1, 8'h75, 1'b1);
    chk("up_blocked_exp", {22'd0, cursor_x, cursor_y, moved}, 32'd0);
    step("up_break", 1'b1, 1'b0, 8'h75, 1'b1);
    for (int i = 0; i < 5; i++) press("to_x5", 8'h23);
    for (int i = 0; i < 3; i++) press("to_y3", 8'h1B);
    chk("at_5_3", {22'd0, cursor_x, cursor_y}, {22'd0, 5'd5, 5'd3});
    step("restart_make", 1'b1, 1'b1, 8'h76, 1'b1);
    chk("restart_pulse", {22'd0, cursor_x, cursor_y, restart, moved}, {22'd0, 10'd0, 2'b11});
    step("restart_break", 1'b1, 1'b0, 8'h76, 1'b1);

    step("hold_down", 1'b1, 1'b1, 8'h72, 1'b1);
    idle("hold_idle", 20);
    chk("hold_y", {27'd0, cursor_y}, AR ? 32'd5 : 32'd1);
    step("hold_break", 1'b1, 1'b0, 8'h72, 1'b1);
    idle("after_break", 12);

    press("reveal", 8'h29);
    press("flag", 8'h2B);
    step("reveal_break_only", 1'b1, 1'b0, 8'h29, 1'b1);

    for (int i = 0; i < 16; i++) press("to_x15", 8'h74);
    step("edge_hold_right", 1'b1, 1'b1, 8'h74, 1'b1);
    idle("edge_repeat", 14);
    chk("edge_x", {27'd0, cursor_x}, 32'd15);

    step("en0_break", 1'b1, 1'b0, 8'h74, 1'b1);
    press("left_once", 8'h6B);
    step("en0_make", 1'b1, 1'b1, 8'h74, 1'b0);
    chk("en0_x", {27'd0, cursor_x}, 32'd14);
    idle("en0_idle", 10);

    step("mid_hold", 1'b1, 1'b1, 8'h72, 1'b1);
    idle("mid_idle", 10);
    apply_reset();
    idle("post_reset", 20);
    chk("post_reset_home", {22'd0, cursor_x, cursor_y}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] c;
      c = codes[$urandom_range(0, 11)];
      if (c == 8'h00) c = 8'($urandom);
      step("rand", ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)), c,
           ($urandom_range(0, 49) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_cursor_ctrl.md
KEY_CURSOR_CTRL -- requirements
Module: key_cursor_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- GRID_W, 16, columns (2..32)
- GRID_H, 16, rows (2..32)
- REPEAT_DELAY, 25000000, cycles from make to first auto-repeat
- REPEAT_PERIOD, 5000000, cycles between auto-repeats
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- CLOCK_50, in, 1, sole clock, rising edge
- reset, in, 1, asynchronous, active-low
- enable, in, 1, accept key events when high
- valid, in, 1, one-cycle key event strobe from the keyboard press stage
- makeBreak, in, 1, 1 = make, 0 = break
- outCode, in, 8, scan code, E0 prefix already stripped
- cursor_x, out, 5, column 0..GRID_W-1
- cursor_y, out, 5, row 0..GRID_H-1
- moved, out, 1, one-cycle pulse on any cursor change
- reveal, out, 1, one-cycle pulse
- flag, out, 1, one-cycle pulse
- restart, out, 1, one-cycle pulse

Function
REQ-003 Key map SHALL be:
- up = 8'h75 or 8'h1D
- down = 8'h72 or 8'h1B
- left = 8'h6B or 8'h1C
- right = 8'h74 or 8'h23
- reveal = 8'h29
- flag = 8'h2B
- restart = 8'h76
- all other codes ignored
REQ-004 Events SHALL be sampled only when valid=1 and enable=1; enable=0 drops events and forces state IDLE.
REQ-005 A direction make SHALL move the cursor one cell, with outputs and moved updated on the first edge after the valid cycle (1-cycle latency).
REQ-006 Movement SHALL saturate at 0 and at GRID_W-1 / GRID_H-1, with no wrap; a blocked move SHALL leave moved=0.
REQ-007 A make of reveal, flag or restart SHALL pulse the matching output for exactly one cycle at the same 1-cycle latency.
REQ-008 Break events SHALL NOT generate action pulses or moves.
REQ-009 restart SHALL also return the cursor to (0,0), and moved SHALL pulse only if the position changed.
REQ-010 Held-direction FSM states SHALL be IDLE, DELAY and REPEAT:
- IDLE -> DELAY on a direction make; store the direction; clear the counter
- DELAY -> REPEAT when the counter reaches REPEAT_DELAY-1; perform one move
- REPEAT performs one move each time the counter reaches REPEAT_PERIOD-1, then clears the counter
- DELAY/REPEAT -> IDLE on a break of the held direction code (either alias)
REQ-011 A make of a different direction while in DELAY or REPEAT SHALL move once, replace the held direction and re-enter DELAY with a cleared counter.
REQ-012 A break of a non-held key SHALL NOT change the FSM state.
REQ-013 A reveal, flag or restart make SHALL NOT alter the held direction.
REQ-014 If a repeat tick and a valid event coincide, the event SHALL take priority and the tick SHALL be discarded.
REQ-015 Only one cursor change SHALL occur per cycle.
REQ-016 The counter SHALL be 26 bits and SHALL NOT advance in IDLE.

Reset
REQ-017 reset low SHALL asynchronously set:
- cursor_x = 0, cursor_y = 0
- moved = reveal = flag = restart = 0
- FSM = IDLE, counter = 0
REQ-018 Assertion mid-repeat SHALL abandon the held key, so that no move follows deassertion until a new make.
REQ-019 Deassertion SHALL be effective on the first rising CLOCK_50 edge after release.

Configuration
REQ-020 Macro KEY_AUTOREPEAT_EN SHALL control auto-repeat:
- defined: DELAY/REPEAT behaviour per REQ-010 to REQ-016
- undefined: FSM and counter absent; one move per direction make; all other behaviour identical

Verification (REPEAT_DELAY=8, REPEAT_PERIOD=4, GRID 16x16)
REQ-021 Reset, then make 8'h74 -> next cycle cursor_x=1, moved=1 for one cycle; cursor_y=0.
REQ-022 Cursor at (0,0), make 8'h75 -> cursor unchanged, moved=0; make 8'h76 at (5,3) -> cursor=(0,0), restart=1 and moved=1 for one cycle.
REQ-023 Hold 8'h72 (make only) from (0,0) for 20 cycles with KEY_AUTOREPEAT_EN:
- cursor_y=1 immediately
- +1 at cycle 9, then every 4 cycles
- break 8'h72 -> no further moves
- without the macro -> cursor_y stays 1
REQ-024 Make 8'h29, then 8'h2B -> reveal, then flag, each one cycle wide one cycle after its valid; break 8'h29 -> no pulse.
REQ-025 Edge and reset cases:
- in REPEAT at x=15 moving right -> x stays 15, moved=0
- assert reset mid-repeat -> all outputs 0; after release, no moves without a new make
REQ-026 enable=0 with make 8'h74 -> no change.
